soc_periph_hub: RTL and testbench
=================================

# soc_periph_hub

Parametrised address-decode and status hub between the single-cycle core's data port and its memory-mapped targets: data memory, a GPIO block, and `NUM_SLOTS` accelerator slots. It generates one-hot write strobes, returns read data through a registered mux with a valid flag, and edge-detects each accelerator's done output into sticky, software-clearable flags. It also provides per-slot interrupt masking and bus-error capture. All state lives in the `clk` domain; done signals are never used as clocks.

## Interface
- `NUM_SLOTS`, 2: accelerator slots, 1..30.
- `DW`, 32: data width.
- `MEM_LIMIT`, 32'h800: memory decodes when addr < MEM_LIMIT.
- `SLOT_BASE`, 32'h800: base address of slot 0.
- `SLOT_STRIDE_LOG2`, 9: slot i base = SLOT_BASE + (i << SLOT_STRIDE_LOG2); each slot window is 16 bytes.
- `GPIO_BASE`, 32'h900: 16-byte GPIO window.
- `HUB_BASE`, 32'hF00: hub registers. +0 STATUS (RO), +4 CLEAR (W1C), +8 IRQ_EN (RW).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `addr` in 32: byte address from the core.
- `wdata` in DW: write data.
- `we` in 1: write strobe.
- `re` in 1: read strobe.
- `rdata` out DW: registered read data.
- `rvalid` out 1: `rdata` valid, one-cycle pulse.
- `periph_addr` out 2: `addr[3:2]`, shared by all targets.
- `mem_we`, `gpio_we` out 1: target write strobes.
- `slot_we` out NUM_SLOTS: per-slot write strobes.
- `mem_rdata`, `gpio_rdata` in DW: target read data.
- `slot_rdata` in NUM_SLOTS*DW: slot i occupies bits [i*DW +: DW].
- `slot_done` in NUM_SLOTS: level done from each accelerator.
- `done_flags` out NUM_SLOTS: sticky done flags.
- `irq` out 1: registered OR of (done_flags & IRQ_EN).

## Operation
- Decode priority: hub window (HUB_BASE..+0xF), then GPIO window, then slot i (offset from SLOT_BASE divisible by 1<<SLOT_STRIDE_LOG2, quotient < NUM_SLOTS, offset bits [STRIDE_LOG2-1:4] zero), then memory (addr < MEM_LIMIT). Anything else is unmapped.
- Write strobes are combinational: `we` AND decode. At most one strobe is high. Unmapped and hub writes raise no external strobe.
- STATUS: bits [NUM_SLOTS-1:0] = flags, bit 31 = bus_err, all other bits 0. Writes to STATUS are ignored.
- CLEAR write: each 1 bit in wdata clears the matching flag or bus_err. Bits beyond NUM_SLOTS are ignored.
- IRQ_EN: bits [NUM_SLOTS-1:0] writable. Read returns the mask, other bits 0. Other hub offsets read 0.
- Done capture: `done_q` registers `slot_done`. A rising edge (slot_done=1, done_q=0) sets flag i.
- Auto-clear: a write to slot i offset 0 (start register) clears flag i.
- Set and clear in the same cycle: set wins.
- bus_err: set by `we` or `re` to an unmapped address. An unmapped read returns 0 with `rvalid` still asserted.
- `we` and `re` together: both act. A hub-register read returns the value before the write.

## Timing
- Reset (rst_n low, asynchronous): rdata=0, rvalid=0, flags=0, bus_err=0, IRQ_EN=0, irq=0, done_q=0. Releasing reset with slot_done already high sets that flag on the first clock edge.
- Write: the target samples `wdata` on the same edge that the strobe is high. Hub registers update on that edge.
- Read: `re` in cycle N gives `rvalid`=1 and `rdata` in cycle N+1. rvalid is low in cycle N+1 if `re` was low in cycle N. Back-to-back reads are supported at one per cycle.
- Flag: slot_done rising before edge k makes the flag visible on `done_flags`/STATUS after edge k. `irq` follows after edge k+1.
- Clearing a flag drops `irq` one edge later.
- A held-high done does not re-set a flag after it is cleared; a new rising edge is required.

## Test plan
- Reset, then read 0x000, 0x800, 0x900, 0xF00 with targets driving 0x11, 0x22, 0x33: rdata = 0x11, 0x22, 0x33, 0 respectively, each one cycle after `re`; all outputs 0 during reset.
- Write to 0xA04 with NUM_SLOTS=2: only slot_we[1]=1 and periph_addr=1. Write to 0x804: only slot_we[0]=1. Write to 0x010: only mem_we=1.
- Pulse slot_done[1] high for 3 cycles: done_flags=2'b10 and STATUS=0x2; irq stays 0. Write IRQ_EN=0x2: irq=1 one cycle later. Write CLEAR=0x2: flag=0, then irq=0 one cycle later.
- Write to 0x800 (slot 0 start) in the same cycle slot_done[0] rises: flag 0 = 1 (set wins). A later start write with done_q high clears flag 0, and it stays 0.
- Read 0x700 with MEM_LIMIT=0x800 (maps to memory, no error). Read 0xC00 (unmapped): rdata=0, rvalid=1, STATUS bit31=1. CLEAR 0x8000_0000 returns STATUS to 0.
- Assert rst_n low mid-read while flags are set: rvalid, flags and irq go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/soc_periph_hub.sv
// soc_periph_hub: address decode, write strobes and registered read mux for the core's
// data port, with sticky accelerator done flags, per-slot IRQ mask and bus-error capture.
module soc_periph_hub #(
    parameter int unsigned NUM_SLOTS        = 2,
    parameter int unsigned DW               = 32,
    parameter logic [31:0] MEM_LIMIT        = 32'h800,
    parameter logic [31:0] SLOT_BASE        = 32'h800,
    parameter int unsigned SLOT_STRIDE_LOG2 = 9,
    parameter logic [31:0] GPIO_BASE        = 32'h900,
    parameter logic [31:0] HUB_BASE         = 32'hF00
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [31:0]             addr,
    input  logic [DW-1:0]           wdata,
    input  logic                    we,
    input  logic                    re,
    output logic [DW-1:0]           rdata,
    output logic                    rvalid,
    output logic [1:0]              periph_addr,
    output logic                    mem_we,
    output logic                    gpio_we,
    output logic [NUM_SLOTS-1:0]    slot_we,
    input  logic [DW-1:0]           mem_rdata,
    input  logic [DW-1:0]           gpio_rdata,
    input  logic [NUM_SLOTS*DW-1:0] slot_rdata,
    input  logic [NUM_SLOTS-1:0]    slot_done,
    output logic [NUM_SLOTS-1:0]    done_flags,
    output logic                    irq
);

    localparam logic [1:0] HUB_STATUS = 2'd0;
    localparam logic [1:0] HUB_CLEAR  = 2'd1;
    localparam logic [1:0] HUB_IRQ_EN = 2'd2;

    logic                 hub_sel, gpio_sel, mem_sel, unmapped;
    logic                 hub_hit, gpio_hit;
    logic [NUM_SLOTS-1:0] slot_hit, slot_sel;
    logic [NUM_SLOTS-1:0] done_q, irq_en, done_rise, clr_flags;
    logic                 bus_err, clr_err, hub_wr;
    logic [DW-1:0]        status, rd_mux;
    logic                 unused_wdata;

    function automatic logic in_window(input logic [31:0] a, input logic [31:0] base);
        return (a >= base) && ((a - base) < 32'd16);
    endfunction

    // Priority-resolved decode: hub, then GPIO, then slots, then memory.
    always_comb begin
        hub_hit  = in_window(addr, HUB_BASE);
        gpio_hit = in_window(addr, GPIO_BASE);
        slot_hit = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            slot_hit[i] = in_window(addr, SLOT_BASE + (32'(i) << SLOT_STRIDE_LOG2));
        end
        hub_sel  = hub_hit;
        gpio_sel = gpio_hit & ~hub_hit;
        slot_sel = (hub_hit | gpio_hit) ? '0 : slot_hit;
        mem_sel  = ~hub_hit & ~gpio_hit & ~(|slot_hit) & (addr < MEM_LIMIT);
        unmapped = ~(hub_sel | gpio_sel | (|slot_sel) | mem_sel);
    end

    assign periph_addr  = addr[3:2];
    assign mem_we       = we & mem_sel;
    assign gpio_we      = we & gpio_sel;
    assign slot_we      = {NUM_SLOTS{we}} & slot_sel;
    assign hub_wr       = we & hub_sel;
    assign unused_wdata = ^wdata;

    // Flag clears come from CLEAR writes and from a write to a slot's start register.
    always_comb begin
        clr_flags = '0;
        if (hub_wr && periph_addr == HUB_CLEAR) begin
            clr_flags = wdata[NUM_SLOTS-1:0];
        end
        if (periph_addr == 2'd0) begin
            clr_flags = clr_flags | slot_we;
        end
        clr_err   = hub_wr && (periph_addr == HUB_CLEAR) && wdata[31];
        done_rise = slot_done & ~done_q;
    end

    always_comb begin
        status                  = '0;
        status[NUM_SLOTS-1:0]   = done_flags;
        status[31]              = bus_err;
        rd_mux                  = '0;
        if (hub_sel) begin
            case (periph_addr)
                HUB_STATUS: rd_mux = status;
                HUB_IRQ_EN: rd_mux[NUM_SLOTS-1:0] = irq_en;
                default:    rd_mux = '0;
            endcase
        end else if (gpio_sel) begin
            rd_mux = gpio_rdata;
        end else if (mem_sel) begin
            rd_mux = mem_rdata;
        end else begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                if (slot_sel[i]) rd_mux = slot_rdata[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata      <= '0;
            rvalid     <= 1'b0;
            done_q     <= '0;
            done_flags <= '0;
            bus_err    <= 1'b0;
            irq_en     <= '0;
            irq        <= 1'b0;
        end else begin
            rvalid <= re;
            if (re) rdata <= rd_mux;
            done_q     <= slot_done;
            // A new rising edge takes precedence over a same-cycle clear.
            done_flags <= (done_flags & ~clr_flags) | done_rise;
            bus_err    <= ((we | re) & unmapped) | (bus_err & ~clr_err);
            if (hub_wr && periph_addr == HUB_IRQ_EN) irq_en <= wdata[NUM_SLOTS-1:0];
            irq        <= |(done_flags & irq_en);
        end
    end

endmodule

// File: tb/tb_soc_periph_hub.sv
// Bench for soc_periph_hub: directed decode table, test-plan sequences and randomized
// traffic checked against a transaction-level model of the hub.
module tb_soc_periph_hub;
    localparam int NS = 2;
    localparam int DW = 32;
    localparam int T_HUB = 100, T_GPIO = 101, T_MEM = 102, T_NONE = -1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [31:0]      addr = '0;
    logic [DW-1:0]    wdata = '0;
    logic             we = 1'b0, re = 1'b0;
    logic [DW-1:0]    rdata;
    logic             rvalid;
    logic [1:0]       periph_addr;
    logic             mem_we, gpio_we;
    logic [NS-1:0]    slot_we;
    logic [DW-1:0]    mem_rdata = '0, gpio_rdata = '0;
    logic [NS*DW-1:0] slot_rdata = '0;
    logic [NS-1:0]    slot_done = '0;
    logic [NS-1:0]    done_flags;
    logic             irq;

    always #5 clk = ~clk;

    soc_periph_hub #(.NUM_SLOTS(NS), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .we(we), .re(re),
        .rdata(rdata), .rvalid(rvalid), .periph_addr(periph_addr),
        .mem_we(mem_we), .gpio_we(gpio_we), .slot_we(slot_we),
        .mem_rdata(mem_rdata), .gpio_rdata(gpio_rdata), .slot_rdata(slot_rdata),
        .slot_done(slot_done), .done_flags(done_flags), .irq(irq)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model state
    logic [NS-1:0] m_flags, m_en, m_dq;
    logic          m_err, m_irq, m_rvalid;
    logic [DW-1:0] m_rdata;

    task automatic m_reset();
        m_flags = '0; m_en = '0; m_dq = '0;
        m_err = 1'b0; m_irq = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    endtask

    function automatic int target(input logic [31:0] a);
        logic [31:0] b;
        if (a >= 32'hF00 && a < 32'hF10) return T_HUB;
        if (a >= 32'h900 && a < 32'h910) return T_GPIO;
        for (int i = 0; i < NS; i++) begin
            b = 32'h800 + 32'(i) * 32'd512;
            if (a >= b && a < b + 32'd16) return i;
        end
        if (a < 32'h800) return T_MEM;
        return T_NONE;
    endfunction

    // One clock: check strobes before the edge, advance model, check registered outputs after.
    task automatic step();
        int            t;
        logic [NS-1:0] exp_slot, clr, rise;
        logic [DW-1:0] rd, status;
        #1;
        t = target(addr);
        exp_slot = '0;
        if (we && t >= 0 && t < NS) exp_slot[t] = 1'b1;
        check("mem_we", mem_we, we && t == T_MEM);
        check("gpio_we", gpio_we, we && t == T_GPIO);
        check("slot_we", slot_we, exp_slot);
        check("periph_addr", periph_addr, addr[3:2]);
        status = '0;
        status[NS-1:0] = m_flags;
        status[31] = m_err;
        rd = '0;
        case (t)
            T_MEM:  rd = mem_rdata;
            T_GPIO: rd = gpio_rdata;
            T_HUB:  begin
                if (addr[3:2] == 2'd0) rd = status;
                else if (addr[3:2] == 2'd2) rd = DW'(m_en);
            end
            default: if (t >= 0) rd = slot_rdata[t*DW +: DW];
        endcase
        clr = '0;
        if (we && t == T_HUB && addr[3:2] == 2'd1) clr = wdata[NS-1:0];
        if (we && t >= 0 && t < NS && addr[3:2] == 2'd0) clr[t] = 1'b1;
        rise = slot_done & ~m_dq;
        @(posedge clk);
        m_irq = |(m_flags & m_en);
        if (we && t == T_HUB && addr[3:2] == 2'd1 && wdata[31]) m_err = 1'b0;
        if ((we || re) && t == T_NONE) m_err = 1'b1;
        if (we && t == T_HUB && addr[3:2] == 2'd2) m_en = wdata[NS-1:0];
        m_flags = (m_flags & ~clr) | rise;
        m_dq = slot_done;
        m_rvalid = re;
        if (re) m_rdata = rd;
        #1;
        check("rvalid", rvalid, m_rvalid);
        check("done_flags", done_flags, m_flags);
        check("irq", irq, m_irq);
        if (m_rvalid) check("rdata", rdata, m_rdata);
    endtask

    task automatic cyc(input logic [31:0] a, input logic w, input logic r, input logic [DW-1:0] d);
        addr = a; we = w; re = r; wdata = d;
        step();
    endtask

    typedef struct {
        logic [31:0]   a;
        logic          mem;
        logic          gpio;
        logic [NS-1:0] slot;
        logic [1:0]    pa;
    } dec_vec_t;

    dec_vec_t vecs[8];

    function automatic logic [31:0] rand_addr();
        logic [31:0] bases[8];
        int          pick;
        bases = '{32'h000, 32'h800, 32'hA00, 32'h900, 32'hF00, 32'hC00, 32'h810, 32'h7F0};
        pick = $urandom_range(0, 7);
        if (pick == 0) return 32'($urandom_range(0, 32'h7FF));
        return bases[pick] + 32'($urandom_range(0, 15));
    endfunction

    initial begin
        vecs[0] = '{32'hA04, 1'b0, 1'b0, 2'b10, 2'd1};
        vecs[1] = '{32'h804, 1'b0, 1'b0, 2'b01, 2'd1};
        vecs[2] = '{32'h010, 1'b1, 1'b0, 2'b00, 2'd0};
        vecs[3] = '{32'h904, 1'b0, 1'b1, 2'b00, 2'd1};
        vecs[4] = '{32'hF08, 1'b0, 1'b0, 2'b00, 2'd2};
        vecs[5] = '{32'h810, 1'b0, 1'b0, 2'b00, 2'd0};
        vecs[6] = '{32'hA10, 1'b0, 1'b0, 2'b00, 2'd0};
        vecs[7] = '{32'h7FC, 1'b1, 1'b0, 2'b00, 2'd3};

        m_reset();
        #12;
        check("rst_rdata", rdata, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_flags", done_flags, 0);
        check("rst_irq", irq, 0);
        check("rst_strobes", {mem_we, gpio_we, slot_we}, 0);
        rst_n = 1'b1;

        mem_rdata = 32'h11; slot_rdata = {32'h44, 32'h22}; gpio_rdata = 32'h33;
        cyc(32'h000, 1'b0, 1'b1, '0); check("rd_mem", rdata, 32'h11);
        cyc(32'h800, 1'b0, 1'b1, '0); check("rd_slot0", rdata, 32'h22);
        cyc(32'h900, 1'b0, 1'b1, '0); check("rd_gpio", rdata, 32'h33);
        cyc(32'hF00, 1'b0, 1'b1, '0); check("rd_status", rdata, 0);
        check("rd_status_valid", rvalid, 1);
        cyc(32'h000, 1'b0, 1'b0, '0); check("rvalid_idle", rvalid, 0);

        for (int i = 0; i < 8; i++) begin
            addr = vecs[i].a; we = 1'b1; re = 1'b0; wdata = '0;
            #1;
            check("vec_mem_we", mem_we, vecs[i].mem);
            check("vec_gpio_we", gpio_we, vecs[i].gpio);
            check("vec_slot_we", slot_we, vecs[i].slot);
            check("vec_periph_addr", periph_addr, vecs[i].pa);
            step();
        end
        cyc(32'hF04, 1'b1, 1'b0, 32'h8000_0003);

        slot_done = 2'b10;
        repeat (3) cyc(32'h000, 1'b0, 1'b0, '0);
        check("flag1_set", done_flags, 2'b10);
        check("irq_masked", irq, 0);
        slot_done = 2'b00;
        cyc(32'hF00, 1'b0, 1'b1, '0); check("status_flag1", rdata, 32'h2);
        cyc(32'hF08, 1'b1, 1'b0, 32'h2); check("irq_en_lag", irq, 0);
        cyc(32'h000, 1'b0, 1'b0, '0); check("irq_on", irq, 1);
        cyc(32'hF04, 1'b1, 1'b0, 32'h2);
        check("flag1_clr", done_flags, 0);
        check("irq_clr_lag", irq, 1);
        cyc(32'h000, 1'b0, 1'b0, '0); check("irq_off", irq, 0);

        slot_done = 2'b01;
        cyc(32'h800, 1'b1, 1'b0, 32'h1); check("set_wins", done_flags[0], 1);
        cyc(32'h000, 1'b0, 1'b0, '0);
        cyc(32'h800, 1'b1, 1'b0, 32'h1); check("start_clr", done_flags[0], 0);
        repeat (2) cyc(32'h000, 1'b0, 1'b0, '0);
        check("held_done_no_reset", done_flags[0], 0);
        slot_done = 2'b00;

        cyc(32'h700, 1'b0, 1'b1, '0); check("rd_700_mem", rdata, 32'h11);
        cyc(32'hF00, 1'b0, 1'b1, '0); check("no_err_700", rdata, 0);
        cyc(32'hC00, 1'b0, 1'b1, '0);
        check("unmapped_rdata", rdata, 0);
        check("unmapped_rvalid", rvalid, 1);
        cyc(32'hF00, 1'b0, 1'b1, '0); check("status_err", rdata, 32'h8000_0000);
        cyc(32'hF04, 1'b1, 1'b0, 32'h8000_0000);
        cyc(32'hF00, 1'b0, 1'b1, '0); check("status_err_clr", rdata, 0);

        for (int n = 0; n < 3000; n++) begin
            mem_rdata = $urandom; gpio_rdata = $urandom;
            slot_rdata = {$urandom, $urandom};
            for (int b = 0; b < NS; b++) if ($urandom_range(0, 3) == 0) slot_done[b] = ~slot_done[b];
            cyc(rand_addr(), $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), $urandom);
        end

        slot_done = 2'b00;
        cyc(32'h000, 1'b0, 1'b0, '0);
        slot_done = 2'b11;
        cyc(32'h000, 1'b0, 1'b0, '0);
        cyc(32'hF08, 1'b1, 1'b0, 32'h3);
        cyc(32'h000, 1'b0, 1'b0, '0);
        cyc(32'h000, 1'b0, 1'b1, '0);
        check("pre_rst_flags", done_flags, 2'b11);
        check("pre_rst_irq", irq, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rvalid", rvalid, 0);
        check("async_flags", done_flags, 0);
        check("async_irq", irq, 0);
        check("async_rdata", rdata, 0);
        m_reset();
        re = 1'b0; slot_done = 2'b01;
        #2 rst_n = 1'b1;
        step();
        check("flag_after_rst", done_flags, 2'b01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
